pipe_ctrl: RTL and testbench

- Central pipeline control unit for the five-stage core.
- Turns per-stage stall requests into a stall vector that freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sequences pipeline flushes (exception/redirect) with a captured target PC.
- Runs a consecutive-stall watchdog for debug.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/stall_watchdog.sv | 34 +++
 rtl/pipe_ctrl.sv | 87 ++++++++
 tb/tb_pipe_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: FSM encodings, stall-bus
// type and freeze patterns, plus the combinational stall decoder.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'b00,
    CTRL_STALL = 2'b01,
    CTRL_FLUSH = 2'b10
  } ctrl_state_e;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  // Bit order: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;

  // A flush overrides any freeze; EX requests dominate ID requests.
  function automatic stall_bus_t stall_decode(input ctrl_state_e st,
                                              input logic        req_id,
                                              input logic        req_ex);
    if (st == CTRL_FLUSH) return STALL_NONE;
    if (req_ex)           return STALL_EX;
    if (req_id)           return STALL_ID;
    return STALL_NONE;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Consecutive-stall watchdog: saturating run counter with a sticky timeout
// flag that rises on the edge the counter reaches MAX_STALL-1.
module stall_watchdog #(
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] PRE_TRIP = CNT_W'(MAX_STALL - 2);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      // The increment on this edge lands the counter on MAX_STALL-1.
      if (cnt >= PRE_TRIP) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: combinational stall vector, RUN/STALL/FLUSH FSM with
// registered flush/busy/new_pc, and a consecutive-stall watchdog.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [STALL_W-1:0]  stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                busy,
  output logic                timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_flush_count
`endif
);

  ctrl_state_e state;
  ctrl_state_e state_nxt;
  logic        wd_inc;
  logic        wd_clr;

  // Freeze must act in the request cycle, so this path is never registered.
  always_comb stall = stall_decode(state, stallreq_id, stallreq_ex);

  // NOTE: a default assignment ahead of the branches keeps this block free of
  // inferred latches.
  always_comb begin
    state_nxt = state;
    if (flush_req)                       state_nxt = CTRL_FLUSH;
    else if (state == CTRL_FLUSH)        state_nxt = CTRL_RUN;
    else if (stallreq_id || stallreq_ex) state_nxt = CTRL_STALL;
    else                                 state_nxt = CTRL_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= CTRL_RUN;
      flush  <= 1'b0;
      busy   <= 1'b0;
      new_pc <= '0;
    end else begin
      state <= state_nxt;
      flush <= (state_nxt == CTRL_FLUSH);
      busy  <= (state_nxt != CTRL_RUN);
      if (flush_req) new_pc <= flush_pc;
    end
  end

  assign wd_inc = (state == CTRL_STALL) && (state_nxt == CTRL_STALL);
  assign wd_clr = ~wd_inc;

  stall_watchdog #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .inc     (wd_inc),
    .clr     (wd_clr),
    .timeout (timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall != STALL_NONE) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush)               perf_flush_count  <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model pushes per-cycle
// expectations to a scoreboard that a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int MAX_STALL = 16;
  localparam int CNT_W     = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic        timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .flush_req   (flush_req),
    .flush_pc    (flush_pc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .busy        (busy),
    .timeout     (timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    logic        timeout;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state (value held after the most recent clock edge).
  typedef enum {M_RUN, M_STALL, M_FLUSH} m_state_e;
  m_state_e    m_st  = M_RUN;
  logic [31:0] m_pc  = '0;
  int          m_cnt = 0;
  logic        m_to  = 1'b0;

  // Drive one cycle of stimulus, queue what the DUT must show in this cycle,
  // then advance the model across the upcoming edge.
  task automatic drive(input logic r, input logic i_id, input logic i_ex,
                       input logic i_fr, input logic [31:0] i_pc);
    exp_t     e;
    m_state_e nxt;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = i_id; stallreq_ex = i_ex;
    flush_req = i_fr; flush_pc = i_pc;

    e.stall = 6'b000000;
    if (m_st != M_FLUSH) begin
      if (i_ex)      e.stall = 6'b001111;
      else if (i_id) e.stall = 6'b000111;
    end
    e.flush   = (m_st == M_FLUSH);
    e.busy    = (m_st != M_RUN);
    e.new_pc  = m_pc;
    e.timeout = m_to;
    sb.push_back(e);

    if (!r) begin
      m_st = M_RUN; m_pc = '0; m_cnt = 0; m_to = 1'b0;
    end else begin
      if (i_fr)                nxt = M_FLUSH;
      else if (m_st == M_FLUSH) nxt = M_RUN;
      else if (i_id || i_ex)   nxt = M_STALL;
      else                     nxt = M_RUN;
      if (i_fr) m_pc = i_pc;
      if (m_st == M_STALL && nxt == M_STALL) begin
        if (m_cnt < MAX_STALL) m_cnt++;
        if (m_cnt == MAX_STALL - 1) m_to = 1'b1;
      end else begin
        m_cnt = 0;
      end
      m_st = nxt;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      got = sb.pop_front();
      n_vec += 5;
      if (stall !== got.stall) begin
        n_err++; $display("FAIL sb_stall t=%0t got %b exp %b", $time, stall, got.stall);
      end
      if (flush !== got.flush) begin
        n_err++; $display("FAIL sb_flush t=%0t got %b exp %b", $time, flush, got.flush);
      end
      if (new_pc !== got.new_pc) begin
        n_err++; $display("FAIL sb_new_pc t=%0t got %h exp %h", $time, new_pc, got.new_pc);
      end
      if (busy !== got.busy) begin
        n_err++; $display("FAIL sb_busy t=%0t got %b exp %b", $time, busy, got.busy);
      end
      if (timeout !== got.timeout) begin
        n_err++; $display("FAIL sb_timeout t=%0t got %b exp %b", $time, timeout, got.timeout);
      end
    end
  end

  task automatic test_reset();
    drive(1'b0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (stall !== 6'b000000 || flush !== 1'b0 || busy !== 1'b0 || new_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_idle got stall=%b flush=%b busy=%b pc=%h exp 000000/0/0/0",
               stall, flush, busy, new_pc);
    end
  endtask

  task automatic test_stall_id();
    drive(1'b1, 1, 0, 0, 32'h0);
    drive(1'b1, 1, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (stall !== 6'b000111 || busy !== 1'b1) begin
      n_err++; $display("FAIL id_stall got stall=%b busy=%b exp 000111/1", stall, busy);
    end
    drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (stall !== 6'b000000 || busy !== 1'b1) begin
      n_err++; $display("FAIL id_drop got stall=%b busy=%b exp 000000/1", stall, busy);
    end
    drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL id_busy_clear got %b exp 0", busy);
    end
  endtask

  task automatic test_stall_ex();
    drive(1'b1, 1, 1, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (stall !== 6'b001111) begin
      n_err++; $display("FAIL ex_priority got %b exp 001111", stall);
    end
    drive(1'b1, 1, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (stall !== 6'b000111) begin
      n_err++; $display("FAIL ex_drop got %b exp 000111", stall);
    end
    drive(1'b1, 0, 0, 0, 32'h0);
    drive(1'b1, 0, 0, 0, 32'h0);
  endtask

  task automatic test_flush();
    drive(1'b1, 0, 1, 1, 32'h0000_0100);
    @(negedge clk);
    n_vec++;
    if (stall !== 6'b001111 || flush !== 1'b0) begin
      n_err++; $display("FAIL flush_req_cycle got stall=%b flush=%b exp 001111/0", stall, flush);
    end
    drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (flush !== 1'b1 || new_pc !== 32'h100 || stall !== 6'b000000) begin
      n_err++;
      $display("FAIL flush_active got flush=%b pc=%h stall=%b exp 1/00000100/000000",
               flush, new_pc, stall);
    end
    drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (flush !== 1'b0 || new_pc !== 32'h100) begin
      n_err++; $display("FAIL flush_end got flush=%b pc=%h exp 0/00000100", flush, new_pc);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 0, 0, 1, 32'h0000_0200);
    drive(1'b1, 0, 0, 1, 32'h0000_0300);
    @(negedge clk);
    n_vec++;
    if (flush !== 1'b1 || new_pc !== 32'h200) begin
      n_err++; $display("FAIL b2b_first got flush=%b pc=%h exp 1/00000200", flush, new_pc);
    end
    drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (flush !== 1'b1 || new_pc !== 32'h300) begin
      n_err++; $display("FAIL b2b_second got flush=%b pc=%h exp 1/00000300", flush, new_pc);
    end
    drive(1'b1, 0, 0, 0, 32'h0);
  endtask

  task automatic test_flush_masks_stall();
    drive(1'b1, 0, 0, 1, 32'h0000_0400);
    drive(1'b1, 1, 1, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (stall !== 6'b000000) begin
      n_err++; $display("FAIL flush_masks_stall got %b exp 000000", stall);
    end
    drive(1'b1, 1, 1, 0, 32'h0);
    drive(1'b1, 0, 0, 0, 32'h0);
    drive(1'b1, 0, 0, 0, 32'h0);
  endtask

  task automatic test_watchdog();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 0, 1, 0, 32'h0);
      if (i == 16 || i == 17) begin
        @(negedge clk);
        n_vec++;
        if (timeout !== (i == 17)) begin
          n_err++; $display("FAIL wd_edge cycle=%0d got %b exp %b", i, timeout, (i == 17));
        end
      end
    end
    drive(1'b1, 0, 0, 0, 32'h0);
    drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL wd_sticky got timeout=%b busy=%b exp 1/0", timeout, busy);
    end
    drive(1'b1, 0, 1, 0, 32'h0);
    drive(1'b1, 0, 1, 0, 32'h0);
    drive(1'b0, 0, 1, 0, 32'h0);
    drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL wd_reset got timeout=%b busy=%b exp 0/0", timeout, busy);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, 0, 0, 1, 32'h0000_0500);
    drive(1'b0, 0, 0, 1, 32'h0000_0600);
    drive(1'b1, 0, 0, 0, 32'h0);
    @(negedge clk);
    n_vec++;
    if (flush !== 1'b0 || new_pc !== 32'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_flush got flush=%b pc=%h busy=%b exp 0/00000000/0",
               flush, new_pc, busy);
    end
    drive(1'b1, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_stall_id();
    test_stall_ex();
    test_flush();
    test_back_to_back();
    test_flush_masks_stall();
    test_watchdog();
    test_reset_mid_flush();
    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_drain got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
